// File: rtl/score_display_pkg.sv
// Shared types and constants for the multi-digit score display.
// FSM encodings, BCD digit type and glyph geometry.
package score_display_pkg;

    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE   = 2'd0;
    localparam fsm_state_t ST_ADD    = 2'd1;
    localparam fsm_state_t ST_COMMIT = 2'd2;

    typedef logic [3:0] bcd_t;
    localparam bcd_t DIGIT_MAX = 4'd9;

    // Native font size; the font is a 4x8 coarse bitmap scaled by 4.
    localparam int GLYPH_W     = 16;
    localparam int GLYPH_H     = 32;
    localparam int GLYPH_SCALE = 4;

    function automatic bcd_t clamp_digit(input logic [3:0] v);
        return (v > DIGIT_MAX) ? DIGIT_MAX : v;
    endfunction

endpackage

// File: rtl/score_glyph_rom.sv
// Digit font lookup: 16x32 glyphs for 0..9, digits above 9 render empty.
// Purely combinational; no handshake.
// Each glyph is eight 4-bit coarse rows, row 0 in the top nibble.
module score_glyph_rom
    import score_display_pkg::*;
(
    input  bcd_t       digit,
    input  logic [4:0] row,
    input  logic [3:0] col,
    output logic       pixel
);

    logic [31:0] glyph;
    logic [2:0]  nib;
    logic [3:0]  row_bits;

    always_comb begin
        case (digit)
            4'd0:    glyph = 32'h6999_9960;
            4'd1:    glyph = 32'h2622_2270;
            4'd2:    glyph = 32'h6912_48F0;
            4'd3:    glyph = 32'hE116_11E0;
            4'd4:    glyph = 32'h999F_1110;
            4'd5:    glyph = 32'hF8E1_1960;
            4'd6:    glyph = 32'h688E_9960;
            4'd7:    glyph = 32'hF122_4440;
            4'd8:    glyph = 32'h6996_9960;
            4'd9:    glyph = 32'h6997_1160;
            default: glyph = 32'h0000_0000;
        endcase
        nib      = 3'd7 - row[4:2];
        row_bits = glyph[nib*4 +: 4];
        pixel    = row_bits[2'd3 - col[3:2]];
    end

endmodule

// File: rtl/score_digits_display.sv
// BCD score keeper with ripple add FSM, bonus doubling and saturation, plus glyph renderer.
// Add: 1 accept cycle then one cycle per digit and a commit cycle; render: 1-cycle pipeline.
// add_ready is low while an add is in flight; requests seen then are dropped, not queued.
module score_digits_display
    import score_display_pkg::*;
#(
    parameter int       NUM_DIGITS    = 4,
    parameter int       DIGIT_W       = 16,
    parameter int       DIGIT_H       = 32,
    parameter logic [7:0] DIGIT_COLOR = 8'hFF,
    parameter bit       BLANK_LEADING = 1'b1,
    parameter int       BLINK_FRAMES  = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [10:0]             offsetX,
    input  logic [10:0]             offsetY,
    input  logic                    InsideRectangle,
    input  logic                    add_valid,
    input  logic [3:0]              add_value,
    output logic                    add_ready,
    input  logic                    bonus,
    input  logic                    lvl_start,
    input  logic                    frame_tick,
    output logic                    drawingRequest,
    output logic [7:0]              RGBout,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic                    saturated
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int COL_W   = (DIGIT_W > 1) ? $clog2(DIGIT_W) : 1;
    localparam int BLINK_W = ($clog2(BLINK_FRAMES + 1) > 4) ? $clog2(BLINK_FRAMES + 1) : 4;

    fsm_state_t              state_q, state_d;
    logic [4*NUM_DIGITS-1:0] work_q, work_d;
    logic [4*NUM_DIGITS-1:0] score_q, score_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [1:0]              carry_q, carry_d;
    logic [4:0]              addend_q, addend_d;
    logic                    sat_q, sat_d;
    logic                    bonus_q, bonus_d;
    logic [BLINK_W-1:0]      blink_q, blink_d;
    logic                    draw_q, draw_d;

    bcd_t       cur_digit;
    logic [4:0] addend_use;
    logic [4:0] digit_sum;
    logic [1:0] sum_carry;
    bcd_t       sum_digit;

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        score_d    = score_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        addend_d   = addend_q;
        sat_d      = sat_q;
        cur_digit  = work_q[idx_q*4 +: 4];
        addend_use = (idx_q == '0) ? addend_q : 5'd0;
        digit_sum  = 5'(cur_digit) + addend_use + 5'(carry_q);
        if (digit_sum >= 5'd20) begin
            sum_digit = 4'(digit_sum - 5'd20);
            sum_carry = 2'd2;
        end else if (digit_sum >= 5'd10) begin
            sum_digit = 4'(digit_sum - 5'd10);
            sum_carry = 2'd1;
        end else begin
            sum_digit = 4'(digit_sum);
            sum_carry = 2'd0;
        end

        case (state_q)
            ST_IDLE: begin
                if (add_valid) begin
                    addend_d = bonus_q ? {clamp_digit(add_value), 1'b0}
                                       : {1'b0, clamp_digit(add_value)};
                    work_d   = score_q;
                    idx_d    = '0;
                    carry_d  = 2'd0;
                    state_d  = ST_ADD;
                end
            end
            ST_ADD: begin
                work_d[idx_q*4 +: 4] = sum_digit;
                carry_d = sum_carry;
                idx_d   = idx_q + IDX_W'(1);
                // Digit 0 always runs; above it, a zero carry leaves the rest untouched.
                if (idx_q == IDX_W'(NUM_DIGITS - 1) || (sum_carry == 2'd0 && idx_q != '0)) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (carry_q != 2'd0) begin
                    score_d = {NUM_DIGITS{DIGIT_MAX}};
                    sat_d   = 1'b1;
                end else begin
                    score_d = work_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bonus_d = bonus_q;
        if (bonus) begin
            bonus_d = 1'b1;
        end else if (lvl_start) begin
            bonus_d = 1'b0;
        end
        blink_d = blink_q;
        if (lvl_start) begin
            blink_d = BLINK_W'(BLINK_FRAMES);
        end else if (frame_tick && blink_q != '0) begin
            blink_d = blink_q - BLINK_W'(1);
        end
    end

    logic [NUM_DIGITS-1:0] blank_vec;
    logic                  nz_seen;

    always_comb begin
        nz_seen   = 1'b0;
        blank_vec = '0;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            nz_seen      = nz_seen | (score_q[d*4 +: 4] != 4'd0);
            blank_vec[d] = BLANK_LEADING && !nz_seen && (d != 0);
        end
    end

    logic [10:0]      slot;
    logic [10:0]      col_ext;
    logic [IDX_W-1:0] dsel;
    logic             in_slot;
    logic             in_glyph;
    logic             blink_hide;
    logic             glyph_pix;

    always_comb begin
        slot       = offsetX >> COL_W;
        col_ext    = offsetX & 11'(DIGIT_W - 1);
        in_slot    = slot < 11'(NUM_DIGITS);
        dsel       = IDX_W'(NUM_DIGITS - 1) - slot[IDX_W-1:0];
        in_glyph   = (offsetY < 11'(DIGIT_H)) && (offsetY < 11'(GLYPH_H)) &&
                     (col_ext < 11'(GLYPH_W));
        blink_hide = (blink_q != '0) && blink_q[3];
        draw_d     = InsideRectangle && in_slot && in_glyph && !blank_vec[dsel] &&
                     !blink_hide && glyph_pix;
    end

    score_glyph_rom u_rom (
        .digit (score_q[dsel*4 +: 4]),
        .row   (offsetY[4:0]),
        .col   (col_ext[3:0]),
        .pixel (glyph_pix)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            score_q  <= '0;
            idx_q    <= '0;
            carry_q  <= 2'd0;
            addend_q <= 5'd0;
            sat_q    <= 1'b0;
            bonus_q  <= 1'b0;
            blink_q  <= '0;
            draw_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            score_q  <= score_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            addend_q <= addend_d;
            sat_q    <= sat_d;
            bonus_q  <= bonus_d;
            blink_q  <= blink_d;
            draw_q   <= draw_d;
        end
    end

    assign add_ready      = (state_q == ST_IDLE);
    assign drawingRequest = draw_q;
    assign RGBout         = DIGIT_COLOR;
    assign score_bcd      = score_q;
    assign saturated      = sat_q;

endmodule

// File: tb/tb_score_digits_display.sv
// Directed bench for score_digits_display: add table, carry/busy/bonus/saturation
// sequences, glyph sweeps against hand-drawn row masks, and the level-start blink window.
module tb_score_digits_display;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] offsetX = '0;
    logic [10:0] offsetY = '0;
    logic        InsideRectangle = 1'b0;
    logic        add_valid = 1'b0;
    logic [3:0]  add_value = '0;
    logic        add_ready;
    logic        bonus = 1'b0;
    logic        lvl_start = 1'b0;
    logic        frame_tick = 1'b0;
    logic        drawingRequest;
    logic [7:0]  RGBout;
    logic [15:0] score_bcd;
    logic        saturated;

    always #5 clk = ~clk;

    score_digits_display dut (
        .clk             (clk),
        .reset           (reset),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .InsideRectangle (InsideRectangle),
        .add_valid       (add_valid),
        .add_value       (add_value),
        .add_ready       (add_ready),
        .bonus           (bonus),
        .lvl_start       (lvl_start),
        .frame_tick      (frame_tick),
        .drawingRequest  (drawingRequest),
        .RGBout          (RGBout),
        .score_bcd       (score_bcd),
        .saturated       (saturated)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        bon;
        logic        lvl;
        logic [3:0]  val;
        logic [15:0] exp_score;
        int          exp_busy;
    } add_vec_t;

    add_vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic b, input logic l);
        bonus = b;
        lvl_start = l;
        @(posedge clk); #1;
        bonus = 1'b0;
        lvl_start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Accept one add, then count cycles with add_ready low (bounded).
    task automatic do_add(input logic [3:0] v, input logic b, output int busy);
        add_value = v;
        add_valid = 1'b1;
        bonus = b;
        @(posedge clk); #1;
        add_valid = 1'b0;
        bonus = 1'b0;
        busy = 0;
        while (add_ready !== 1'b1 && busy < 40) begin
            @(posedge clk); #1;
            busy++;
        end
    endtask

    task automatic sweep(input logic [10:0] y, input logic [63:0] exp_row, input string tag);
        logic [63:0] row;
        row = exp_row;
        offsetY = y;
        for (int x = 0; x < 64; x++) begin
            offsetX = 11'(x);
            @(posedge clk); #1;
            chk($sformatf("%s x=%0d", tag, x), 32'(drawingRequest), 32'(row[63-x]));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        int cnt;
        logic okmid;

        vecs[0] = '{1'b0, 1'b0, 4'd7,  16'h0007, 3};
        vecs[1] = '{1'b0, 1'b0, 4'd5,  16'h0012, 3};
        vecs[2] = '{1'b0, 1'b0, 4'd15, 16'h0021, 3};
        vecs[3] = '{1'b1, 1'b0, 4'd9,  16'h0039, 3};
        vecs[4] = '{1'b0, 1'b1, 4'd9,  16'h0048, 3};
        vecs[5] = '{1'b1, 1'b0, 4'd9,  16'h0066, 3};
        vecs[6] = '{1'b0, 1'b0, 4'd0,  16'h0066, 3};

        #1 reset = 1'b1;
        #2;
        chk("rst score", 32'(score_bcd), 32'h0);
        chk("rst ready", 32'(add_ready), 32'h1);
        chk("rst sat", 32'(saturated), 32'h0);
        chk("rst draw", 32'(drawingRequest), 32'h0);
        chk("rgb", 32'(RGBout), 32'hFF);
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].bon || vecs[i].lvl) pulse(vecs[i].bon, vecs[i].lvl);
            do_add(vecs[i].val, 1'b0, busy);
            chk($sformatf("vec%0d score", i), 32'(score_bcd), 32'(vecs[i].exp_score));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
        end

        // 0999 + 1 ripples through all four digits; a request while busy is dropped.
        do_reset();
        for (int k = 0; k < 111; k++) do_add(4'd9, 1'b0, busy);
        chk("to 0999", 32'(score_bcd), 32'h0999);
        add_value = 4'd1;
        add_valid = 1'b1;
        @(posedge clk); #1;
        add_valid = 1'b0;
        busy = 0;
        okmid = 1'b1;
        while (add_ready !== 1'b1 && busy < 40) begin
            if (score_bcd !== 16'h0999) okmid = 1'b0;
            add_value = 4'd9;
            add_valid = (busy == 1);
            @(posedge clk); #1;
            busy++;
        end
        add_valid = 1'b0;
        chk("ripple busy", 32'(busy), 32'd5);
        chk("ripple score", 32'(score_bcd), 32'h1000);
        chk("no intermediate", 32'(okmid), 32'h1);
        @(posedge clk); #1;
        chk("busy add dropped", 32'(score_bcd), 32'h1000);
        chk("ready after", 32'(add_ready), 32'h1);

        // Bonus arming, clearing and same-cycle priority.
        do_reset();
        do_add(4'd5, 1'b0, busy);
        pulse(1'b1, 1'b0);
        do_add(4'd9, 1'b0, busy);
        chk("bonus 18", 32'(score_bcd), 32'h0023);
        pulse(1'b0, 1'b1);
        do_add(4'd9, 1'b0, busy);
        chk("lvl clears bonus", 32'(score_bcd), 32'h0032);
        do_add(4'd1, 1'b1, busy);
        chk("bonus same cycle", 32'(score_bcd), 32'h0033);
        do_add(4'd1, 1'b0, busy);
        chk("bonus next add", 32'(score_bcd), 32'h0035);
        pulse(1'b1, 1'b1);
        do_add(4'd2, 1'b0, busy);
        chk("bonus wins", 32'(score_bcd), 32'h0039);

        // Saturation at 9999, adds still handshake, then async reset mid-add.
        do_reset();
        pulse(1'b1, 1'b0);
        for (int k = 0; k < 555; k++) do_add(4'd9, 1'b0, busy);
        chk("to 9990", 32'(score_bcd), 32'h9990);
        pulse(1'b0, 1'b1);
        do_add(4'd5, 1'b0, busy);
        chk("to 9995", 32'(score_bcd), 32'h9995);
        chk("not sat", 32'(saturated), 32'h0);
        pulse(1'b1, 1'b0);
        do_add(4'd9, 1'b0, busy);
        chk("sat score", 32'(score_bcd), 32'h9999);
        chk("sat flag", 32'(saturated), 32'h1);
        do_add(4'd3, 1'b0, busy);
        chk("sat handshake", 32'(busy), 32'd5);
        chk("sat hold", 32'(score_bcd), 32'h9999);
        chk("sat sticky", 32'(saturated), 32'h1);
        add_value = 4'd1;
        add_valid = 1'b1;
        @(posedge clk); #1;
        add_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("mid rst score", 32'(score_bcd), 32'h0);
        chk("mid rst sat", 32'(saturated), 32'h0);
        chk("mid rst ready", 32'(add_ready), 32'h1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Rendering: score 0 shows only the units digit.
        InsideRectangle = 1'b1;
        sweep(11'd0, 64'h0000_0000_0000_0FF0, "zero y0");
        for (int k = 0; k < 4; k++) do_add(4'd9, 1'b0, busy);
        do_add(4'd6, 1'b0, busy);
        chk("to 0042", 32'(score_bcd), 32'h0042);
        sweep(11'd10, 64'h0000_0000_F00F_000F, "s42 y10");
        sweep(11'd0, 64'h0000_0000_F00F_0FF0, "s42 y0");
        offsetY = 11'd10;
        offsetX = 11'd32;
        @(posedge clk); #1;
        offsetX = 11'd36;
        #1;
        chk("render latency", 32'(drawingRequest), 32'h1);
        @(posedge clk); #1;
        chk("render next", 32'(drawingRequest), 32'h0);
        offsetX = 11'd64;
        @(posedge clk); #1;
        chk("slot past end", 32'(drawingRequest), 32'h0);
        offsetX = 11'd32;
        offsetY = 11'd32;
        @(posedge clk); #1;
        chk("row past end", 32'(drawingRequest), 32'h0);
        offsetY = 11'd10;
        InsideRectangle = 1'b0;
        @(posedge clk); #1;
        chk("outside rect", 32'(drawingRequest), 32'h0);
        InsideRectangle = 1'b1;

        // Level-start blink at a lit pixel of digit 4.
        pulse(1'b0, 1'b1);
        @(posedge clk); #1;
        cnt = 64;
        chk("blink load", 32'(drawingRequest), 32'h1);
        for (int t = 1; t <= 70; t++) begin
            frame_tick = 1'b1;
            @(posedge clk); #1;
            frame_tick = 1'b0;
            @(posedge clk); #1;
            if (cnt > 0) cnt--;
            chk($sformatf("blink t=%0d", t), 32'(drawingRequest),
                32'((cnt == 0) || (((cnt >> 3) & 1) == 0)));
        end

        // Interior zero in 0102 is drawn; only the leading zero is blanked.
        for (int k = 0; k < 6; k++) do_add(4'd9, 1'b0, busy);
        do_add(4'd6, 1'b0, busy);
        chk("to 0102", 32'(score_bcd), 32'h0102);
        sweep(11'd0, 64'h0000_00F0_0FF0_0FF0, "s102 y0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
